// File: rtl/beat_sequencer.sv
// Tempo and beat source for the note-check stage: steps a beat index through the song,
// judges the hit count against the required count at each beat boundary, and ends in win or loss.
module beat_sequencer #(
  parameter int BEAT_DIV  = 25000000,
  parameter int LAST_BEAT = 96,
  parameter int DIV_W     = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] hit_cnt,
  input  logic [5:0] req_cnt,
  output logic [6:0] beat_cnt,
  output logic       beat_tick,
  output logic [1:0] state,
  output logic       game_over,
  output logic       song_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_END   = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BEAT_DIV - 1);
  localparam logic [6:0]       BEAT_LAST = 7'(LAST_BEAT);

  state_t           st;
  logic [DIV_W-1:0] div;

  assign state = st;

  // NOTE: every register here is state, so the whole block uses non-blocking
  // assignments; reset is synchronous and wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      beat_cnt  <= 7'd0;
      div       <= '0;
      beat_tick <= 1'b0;
      game_over <= 1'b0;
      song_done <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      case (st)
        S_IDLE, S_END: begin
          if (start) begin
            st        <= S_RUN;
            beat_cnt  <= 7'd1;
            div       <= '0;
            beat_tick <= 1'b1;
            game_over <= 1'b0;
            song_done <= 1'b0;
          end
        end
        S_RUN: begin
          // Pause beats a coincident boundary; div stays put so the boundary
          // is re-evaluated on the first cycle after resume.
          if (pause) begin
            st <= S_PAUSE;
          end else if (div == DIV_LAST) begin
            div <= '0;
            if (hit_cnt < req_cnt) begin
              st        <= S_END;
              game_over <= 1'b1;
            end else if (beat_cnt == BEAT_LAST) begin
              st        <= S_END;
              song_done <= 1'b1;
            end else begin
              beat_cnt  <= beat_cnt + 7'd1;
              beat_tick <= 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_PAUSE: begin
          if (!pause) st <= S_RUN;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed scenarios plus a random soak,
// all compared against a progress-count reference model.
module tb_beat_sequencer;

  localparam int BD = 4;
  localparam int LB = 96;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_END   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] hit_cnt = 6'd0;
  logic [5:0] req_cnt = 6'd0;
  logic [6:0] beat_cnt;
  logic       beat_tick;
  logic [1:0] state;
  logic       game_over;
  logic       song_done;

  beat_sequencer #(.BEAT_DIV(BD), .LAST_BEAT(LB), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .hit_cnt(hit_cnt), .req_cnt(req_cnt),
    .beat_cnt(beat_cnt), .beat_tick(beat_tick), .state(state),
    .game_over(game_over), .song_done(song_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int dut_ticks = 0;

  // Reference model: song position is the number of un-paused RUN cycles since start.
  int m_ph = P_IDLE;
  int prog = 0;
  int end_beat = 0;
  bit m_tick = 0, m_go = 0, m_sd = 0;
  int req_tab [0:127];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int m_beat();
    if (m_ph == P_IDLE) return 0;
    if (m_ph == P_END)  return end_beat;
    return prog / BD + 1;
  endfunction

  task automatic step(input bit r, input bit s, input bit p, input bit miss);
    int req, hit;
    req = req_tab[m_beat()];
    if (miss && req > 0) hit = req - 1;
    else hit = (req + int'($urandom_range(0, 3)) > 63) ? 63 : req + int'($urandom_range(0, 3));
    rst = r; start = s; pause = p;
    req_cnt = 6'(req); hit_cnt = 6'(hit);
    @(posedge clk);
    if (r) begin
      m_ph = P_IDLE; prog = 0; end_beat = 0; m_tick = 0; m_go = 0; m_sd = 0;
    end else begin
      m_tick = 0;
      case (m_ph)
        P_IDLE, P_END: if (s) begin
          m_ph = P_RUN; prog = 0; m_go = 0; m_sd = 0; m_tick = 1;
        end
        P_PAUSE: if (!p) m_ph = P_RUN;
        default: begin
          if (p) m_ph = P_PAUSE;
          else begin
            prog++;
            if (prog % BD == 0) begin
              if (hit < req) begin
                m_ph = P_END; m_go = 1; end_beat = prog / BD;
              end else if (prog / BD == LB) begin
                m_ph = P_END; m_sd = 1; end_beat = LB;
              end else m_tick = 1;
            end
          end
        end
      endcase
    end
    #1;
    if (beat_tick) dut_ticks++;
    check("state", int'(state), m_ph);
    check("beat_cnt", int'(beat_cnt), m_beat());
    check("beat_tick", int'(beat_tick), int'(m_tick));
    check("game_over", int'(game_over), int'(m_go));
    check("song_done", int'(song_done), int'(m_sd));
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (prog < target && m_ph == P_RUN && n < 1000) begin
      step(0, 0, 0, 0);
      n++;
    end
    check("reach_beat", int'(beat_cnt), target / BD + 1);
  endtask

  initial begin
    int n;
    int pause_left;
    bit p, s, r, miss;
    for (int i = 0; i < 128; i++) req_tab[i] = int'($urandom_range(1, 40));

    // Reset held for two cycles.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("idle_beat", int'(beat_cnt), 0);

    // Full song with hit == req and occasional short pauses.
    dut_ticks = 0;
    step(0, 1, 0, 0);
    n = 0;
    while (m_ph != P_END && n < 3000) begin
      step(0, 0, ($urandom_range(0, 9) == 0), 0);
      n++;
    end
    check("song_ticks", dut_ticks, LB);
    check("song_end_state", int'(state), 3);
    check("song_done_flag", int'(song_done), 1);
    check("song_end_beat", int'(beat_cnt), LB);

    // Miss at the end of beat 2.
    req_tab[2] = 2;
    step(0, 1, 0, 0);
    run_to(4);
    n = 0;
    while (m_ph == P_RUN && n < 20) begin
      step(0, 0, 0, 1);
      n++;
    end
    check("miss_state", int'(state), 3);
    check("miss_game_over", int'(game_over), 1);
    check("miss_song_done", int'(song_done), 0);
    check("miss_beat", int'(beat_cnt), 2);
    dut_ticks = 0;
    for (int i = 0; i < 6; i++) step(0, 0, (i % 2 == 1), 0);
    check("no_tick_after_end", dut_ticks, 0);

    // Restart from END.
    step(0, 1, 0, 0);
    check("restart_state", int'(state), 1);
    check("restart_beat", int'(beat_cnt), 1);
    check("restart_tick", int'(beat_tick), 1);
    check("restart_game_over", int'(game_over), 0);

    // Pause in beat 5 at div=2 for 10 cycles.
    run_to(18);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    check("paused_beat", int'(beat_cnt), 5);
    check("paused_state", int'(state), 2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("resume_beat_hold", int'(beat_cnt), 5);
    step(0, 0, 0, 0);
    check("resume_beat_next", int'(beat_cnt), 6);
    check("resume_tick", int'(beat_tick), 1);

    // Start is ignored while running.
    run_to(24);
    step(0, 1, 0, 0);
    check("start_in_run_beat", int'(beat_cnt), 7);
    check("start_in_run_state", int'(state), 1);

    // Reset mid-song, then restart.
    run_to(156);
    step(1, 0, 0, 0);
    check("midreset_state", int'(state), 0);
    check("midreset_beat", int'(beat_cnt), 0);
    step(0, 1, 0, 0);
    check("post_reset_beat", int'(beat_cnt), 1);

    // Random soak.
    pause_left = 0;
    for (int i = 0; i < 5000; i++) begin
      if (pause_left > 0) pause_left--;
      else if ($urandom_range(0, 11) == 0) pause_left = int'($urandom_range(1, 8));
      p = (pause_left > 0);
      s = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 599) == 0);
      miss = ($urandom_range(0, 29) == 0);
      step(r, s, p, miss);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Upstream tempo and beat source for the note-check stage. Generates the 7-bit beat index (1..LAST_BEAT) that the check stage maps to a required-note count. Consumes that count back, compares it against the player's hit count at each beat boundary, and ends the song with a win (song_done) or a loss (game_over). Provides start, pause and restart control for the game top level.

Parameters:
BEAT_DIV, 25000000, clock cycles per beat (4 beats/s at 100 MHz); must be >= 2
LAST_BEAT, 96, final beat index of the song; must be <= 127
DIV_W, 25, width of the tempo divider counter; must hold BEAT_DIV-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; starts or restarts the song
pause  input  1  level; freezes the song while high
hit_cnt  input  6  notes correctly hit so far (from the key-judge stage)
req_cnt  input  6  notes required by the current beat (check-stage output for beat_cnt)
beat_cnt  output  7  current beat index; 0 when idle
beat_tick  output  1  one-cycle pulse whenever beat_cnt takes a new value in RUN
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=END
game_over  output  1  set in END when the player fell behind
song_done  output  1  set in END when all LAST_BEAT beats completed

Behaviour:
- One clock domain; all registers update on the rising edge of clk.
- Reset, synchronous, highest priority. Next edge forces:
  - state=IDLE, beat_cnt=0, div=0
  - beat_tick=0, game_over=0, song_done=0
- Reset mid-song aborts with no flag set.
- IDLE:
  - start=1 -> RUN, beat_cnt=1, div=0, beat_tick=1 for that cycle.
  - pause is ignored.
- RUN:
  - div increments by 1 each cycle.
  - The beat boundary is the cycle where div==BEAT_DIV-1 and pause=0. On that edge div returns to 0, then rules apply in this priority:
    - hit_cnt < req_cnt (unsigned): -> END, game_over=1, beat_cnt held.
    - else beat_cnt==LAST_BEAT: -> END, song_done=1, beat_cnt held at LAST_BEAT.
    - else beat_cnt += 1, beat_tick=1 for one cycle.
  - Each beat therefore lasts exactly BEAT_DIV cycles. beat_cnt never wraps past LAST_BEAT.
  - pause=1 -> PAUSE on the next edge. div does not advance on that edge.
  - Pause has priority over a coincident beat boundary. That boundary is evaluated on the first RUN cycle after resume.
  - start is ignored in RUN.
- PAUSE:
  - div and beat_cnt are frozen; beat_tick=0.
  - pause=0 -> RUN; div resumes from its frozen value.
  - start is ignored.
- END:
  - beat_cnt and flags are held.
  - start=1 -> RUN, beat_cnt=1, div=0, both flags cleared, beat_tick=1.
- game_over and song_done are mutually exclusive; both are 0 outside END.
- req_cnt is treated as combinational from beat_cnt, so it is valid in the same cycle. It is sampled only at boundaries.
- beat_tick is registered and asserts in the cycle beat_cnt shows its new value.
- Priority on any edge: rst > start (IDLE/END only) > pause > boundary.
- Target size: about 150–200 lines of RTL.

Test Plan:
(BEAT_DIV=4, LAST_BEAT=96)
1. Reset: rst=1 for 2 cycles, then 0 -> state=0, beat_cnt=0, beat_tick=0, game_over=0, song_done=0.
2. Full song: start pulse, hit_cnt driven equal to req_cnt -> beat_cnt=1 for 4 cycles, then 2, …, 96. beat_tick pulses 96 times. After 4 cycles at 96: state=3, song_done=1, beat_cnt=96.
3. Miss: start, req_cnt=2 during beat 2, hit_cnt=1 at its boundary -> state=3, game_over=1, song_done=0, beat_cnt stays 2, no further beat_tick.
4. Pause: in beat 5 at div=2, pause=1 for 10 cycles -> beat_cnt=5 throughout. After pause=0, beat_cnt becomes 6 after exactly 2 RUN cycles.
5. Start handling: start pulse in RUN at beat 7 -> no change. Start pulse in END (after test 3) -> state=1, beat_cnt=1, game_over=0, beat_tick=1.
6. Reset mid-song: rst=1 at beat 40 -> next cycle state=0, beat_cnt=0, flags 0. Start then resumes from beat 1.
